// File: rtl/uart_rx_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_pkg
// Purpose  : Shared UART RX constants (word width, prescale width, bit order)
// Revision : 1.0
// ============================================================================
package uart_rx_pkg;

    localparam int c_DATA_WIDTH_DEF  = 8;
    localparam int c_PRESC_WIDTH_DEF = 6;

    localparam int c_LSB_FIRST = 0;
    localparam int c_MSB_FIRST = 1;

    typedef enum logic {
        ORDER_LSB_FIRST = 1'b0,
        ORDER_MSB_FIRST = 1'b1
    } bit_order_e;

endpackage
`default_nettype wire

// File: rtl/rx_word_deserializer.sv
`default_nettype none
// ============================================================================
// Module   : rx_word_deserializer
// Purpose  : Collects strobed RX bits into a word; publishes word, parity, valid
// Revision : 1.0
// ============================================================================
module rx_word_deserializer
    import uart_rx_pkg::*;
#(
    parameter int DATA_WIDTH  = c_DATA_WIDTH_DEF,
    parameter int PRESC_WIDTH = c_PRESC_WIDTH_DEF,
    parameter int MSB_FIRST   = c_LSB_FIRST
) (
    input  logic                             CLK,
    input  logic                             RST,
    input  logic                             sampled_bit,
    input  logic                             Enable,
    input  logic                             clear,
    input  logic [PRESC_WIDTH-1:0]           edge_count,
    input  logic [PRESC_WIDTH-1:0]           Prescale,
    output logic [DATA_WIDTH-1:0]            P_DATA,
    output logic                             data_valid,
    output logic                             data_parity,
    output logic [$clog2(DATA_WIDTH+1)-1:0]  bit_cnt
);

    localparam int                 c_CNT_W    = $clog2(DATA_WIDTH + 1);
    localparam logic [c_CNT_W-1:0] c_LAST_BIT = c_CNT_W'(DATA_WIDTH - 1);

    logic [PRESC_WIDTH-1:0] w_sample_edge;
    logic                   w_strobe;
    logic [DATA_WIDTH-1:0]  w_word;
    logic [DATA_WIDTH-2:0]  r_shift;
    logic [DATA_WIDTH-1:0]  r_p_data;
    logic                   r_valid;
    logic                   r_parity;
    logic [c_CNT_W-1:0]     r_bit_cnt;

    // Prescale of zero wraps to all-ones, matching the free-running edge counter
    assign w_sample_edge = Prescale - PRESC_WIDTH'(1);
    assign w_strobe      = Enable && (edge_count == w_sample_edge);

    // Only the W-1 older bits are stored; the newest bit completes the word combinationally
    generate
        if (MSB_FIRST == c_MSB_FIRST) begin : g_msb_first
            assign w_word = {r_shift, sampled_bit};
        end else begin : g_lsb_first
            assign w_word = {sampled_bit, r_shift};
        end
    endgenerate

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_shift   <= '0;
            r_p_data  <= '0;
            r_valid   <= 1'b0;
            r_parity  <= 1'b0;
            r_bit_cnt <= '0;
        end else begin
            r_valid <= 1'b0;
            if (clear) begin
                r_shift   <= '0;
                r_bit_cnt <= '0;
            end else if (w_strobe) begin
                if (MSB_FIRST == c_MSB_FIRST) begin
                    r_shift <= w_word[DATA_WIDTH-2:0];
                end else begin
                    r_shift <= w_word[DATA_WIDTH-1:1];
                end
                if (r_bit_cnt == c_LAST_BIT) begin
                    r_p_data  <= w_word;
                    r_parity  <= ^w_word;
                    r_valid   <= 1'b1;
                    r_bit_cnt <= '0;
                end else begin
                    r_bit_cnt <= r_bit_cnt + c_CNT_W'(1);
                end
            end
        end
    end

    assign P_DATA      = r_p_data;
    assign data_valid  = r_valid;
    assign data_parity = r_parity;
    assign bit_cnt     = r_bit_cnt;

endmodule
`default_nettype wire

// File: tb/tb_rx_word_deserializer.sv
`default_nettype none
// ============================================================================
// Module   : tb_rx_word_deserializer
// Purpose  : Self-checking bench for three deserializer configurations
// Revision : 1.0
// ============================================================================
module tb_rx_word_deserializer;

    logic       clk = 1'b0;
    logic       rst, sb, en, clr;
    logic [5:0] ec, pre;

    logic [7:0] pd_a, pd_b;
    logic [6:0] pd_c;
    logic       dv_a, dv_b, dv_c, par_a, par_b, par_c;
    logic [3:0] bc_a, bc_b;
    logic [2:0] bc_c;

    int n_checks = 0;
    int n_fail   = 0;

    int widths [3] = '{8, 8, 7};
    int msbf   [3] = '{0, 1, 0};
    int m_cnt  [3];
    int m_bits [3][9];
    int m_pd   [3];
    int m_par  [3];
    int m_dv   [3];

    always #5 clk = ~clk;

    rx_word_deserializer #(.DATA_WIDTH(8), .PRESC_WIDTH(6), .MSB_FIRST(0)) u_lsb8 (
        .CLK(clk), .RST(rst), .sampled_bit(sb), .Enable(en), .clear(clr),
        .edge_count(ec), .Prescale(pre), .P_DATA(pd_a), .data_valid(dv_a),
        .data_parity(par_a), .bit_cnt(bc_a));

    rx_word_deserializer #(.DATA_WIDTH(8), .PRESC_WIDTH(6), .MSB_FIRST(1)) u_msb8 (
        .CLK(clk), .RST(rst), .sampled_bit(sb), .Enable(en), .clear(clr),
        .edge_count(ec), .Prescale(pre), .P_DATA(pd_b), .data_valid(dv_b),
        .data_parity(par_b), .bit_cnt(bc_b));

    rx_word_deserializer #(.DATA_WIDTH(7), .PRESC_WIDTH(6), .MSB_FIRST(0)) u_lsb7 (
        .CLK(clk), .RST(rst), .sampled_bit(sb), .Enable(en), .clear(clr),
        .edge_count(ec), .Prescale(pre), .P_DATA(pd_c), .data_valid(dv_c),
        .data_parity(par_c), .bit_cnt(bc_c));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: bits are collected in arrival order and weighted arithmetically at word end
    task automatic model_update();
        int word;
        bit strobe;
        strobe = en && (int'(ec) == ((int'(pre) + 63) % 64));
        for (int k = 0; k < 3; k++) begin
            if (rst) begin
                m_cnt[k] = 0; m_pd[k] = 0; m_par[k] = 0; m_dv[k] = 0;
            end else begin
                m_dv[k] = 0;
                if (clr) begin
                    m_cnt[k] = 0;
                end else if (strobe) begin
                    m_bits[k][m_cnt[k]] = int'(sb);
                    m_cnt[k]++;
                    if (m_cnt[k] == widths[k]) begin
                        word = 0;
                        for (int i = 0; i < widths[k]; i++) begin
                            if (msbf[k] != 0) word += m_bits[k][i] * (1 << (widths[k] - 1 - i));
                            else              word += m_bits[k][i] * (1 << i);
                        end
                        m_pd[k]  = word;
                        m_par[k] = $countones(word) % 2;
                        m_dv[k]  = 1;
                        m_cnt[k] = 0;
                    end
                end
            end
        end
    endtask

    task automatic check_all();
        check("lsb8_pdata",  32'(pd_a),  m_pd[0]);
        check("lsb8_valid",  32'(dv_a),  m_dv[0]);
        check("lsb8_parity", 32'(par_a), m_par[0]);
        check("lsb8_bitcnt", 32'(bc_a),  m_cnt[0]);
        check("msb8_pdata",  32'(pd_b),  m_pd[1]);
        check("msb8_valid",  32'(dv_b),  m_dv[1]);
        check("msb8_parity", 32'(par_b), m_par[1]);
        check("msb8_bitcnt", 32'(bc_b),  m_cnt[1]);
        check("lsb7_pdata",  32'(pd_c),  m_pd[2]);
        check("lsb7_valid",  32'(dv_c),  m_dv[2]);
        check("lsb7_parity", 32'(par_c), m_par[2]);
        check("lsb7_bitcnt", 32'(bc_c),  m_cnt[2]);
    endtask

    task automatic step(input logic r, input logic e, input logic [5:0] c_ec,
                        input logic [5:0] c_pre, input logic b, input logic c);
        rst = r; en = e; ec = c_ec; pre = c_pre; sb = b; clr = c;
        @(posedge clk);
        #1;
        model_update();
        check_all();
    endtask

    task automatic send_bit(input logic b, input int gap);
        for (int g = 0; g < gap; g++)
            step(1'b0, 1'b1, 6'($urandom_range(0, 6)), 6'd8, 1'($urandom), 1'b0);
        step(1'b0, 1'b1, 6'd7, 6'd8, b, 1'b0);
    endtask

    task automatic send_word(input logic [31:0] value, input int w, input int msb, input int gap);
        for (int i = 0; i < w; i++)
            send_bit(msb != 0 ? value[w - 1 - i] : value[i], gap);
    endtask

    task automatic do_clear();
        step(1'b0, 1'b0, 6'd0, 6'd8, 1'b0, 1'b1);
    endtask

    initial begin
        logic [31:0] v;
        logic [5:0]  rp;
        rst = 1'b1; en = 1'b0; ec = '0; pre = 6'd8; sb = 1'b0; clr = 1'b0;

        // Reset state
        step(1'b1, 1'b0, 6'd0, 6'd8, 1'b0, 1'b0);
        step(1'b1, 1'b1, 6'd7, 6'd8, 1'b1, 1'b1);
        check("reset_pdata", 32'(pd_a), 32'h0);

        // Sequence 1,0,1,0,0,1,0,1 -> 0xA5 in both orders
        v = 32'b1010_0101;
        send_word(v, 8, 0, 3);
        check("seq_a5_lsb", 32'(pd_a), 32'hA5);
        check("seq_a5_msb", 32'(pd_b), 32'hA5);
        check("seq_a5_par", 32'(par_a), 32'h0);
        step(1'b0, 1'b0, 6'd0, 6'd8, 1'b0, 1'b0);
        check("a5_valid_drop", 32'(dv_a), 32'h0);

        // Idle: Enable low or off-strobe edge_count with toggling data
        do_clear();
        for (int i = 0; i < 100; i++) begin
            if (i % 2 == 0) step(1'b0, 1'b0, 6'd7, 6'd8, 1'(i % 4 == 0), 1'b0);
            else            step(1'b0, 1'b1, 6'($urandom_range(0, 6)), 6'd8, 1'(i % 3 == 0), 1'b0);
        end
        check("idle_bitcnt", 32'(bc_a), 32'h0);

        // Clear colliding with a strobe drops that bit
        send_word(32'h5, 4, 0, 1);
        step(1'b0, 1'b1, 6'd7, 6'd8, 1'b1, 1'b1);
        check("clr_bitcnt", 32'(bc_a), 32'h0);
        check("clr_pdata_hold", 32'(pd_a), 32'hA5);
        send_word(32'hFF, 8, 0, 2);
        check("ff_pdata", 32'(pd_a), 32'hFF);
        check("ff_parity", 32'(par_a), 32'h0);

        // Reset mid-word
        do_clear();
        send_word(32'h3C, 8, 0, 2);
        check("w1_3c", 32'(pd_a), 32'h3C);
        send_word(32'h1B, 5, 0, 1);
        step(1'b1, 1'b0, 6'd0, 6'd8, 1'b0, 1'b0);
        check("rst_pdata", 32'(pd_a), 32'h0);
        check("rst_bitcnt", 32'(bc_a), 32'h0);
        send_word(32'h81, 8, 0, 2);
        check("w_81", 32'(pd_a), 32'h81);
        check("w_81_par", 32'(par_a), 32'h0);

        // Seven-bit back-to-back words, strobe every cycle
        do_clear();
        send_word(32'h55, 7, 0, 0);
        check("w7_55", 32'(pd_c), 32'h55);
        v = 32'h2A;
        for (int i = 0; i < 6; i++) send_bit(v[i], 0);
        check("w7_55_hold", 32'(pd_c), 32'h55);
        send_bit(v[6], 0);
        check("w7_2a", 32'(pd_c), 32'h2A);
        check("w7_2a_valid", 32'(dv_c), 32'h1);

        // Prescale of zero strobes at edge_count all-ones
        do_clear();
        step(1'b0, 1'b1, 6'd63, 6'd0, 1'b1, 1'b0);
        check("presc0_bitcnt", 32'(bc_a), 32'h1);

        // Randomized traffic
        rp = 6'd8;
        for (int i = 0; i < 600; i++) begin
            if (i % 50 == 0) rp = ($urandom_range(0, 3) == 0) ? 6'd0 : 6'($urandom_range(0, 63));
            step(1'($urandom_range(0, 199) == 0),
                 1'($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 1) == 0) ? rp - 6'd1 : 6'($urandom_range(0, 63)),
                 rp,
                 1'($urandom),
                 1'($urandom_range(0, 39) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rx_word_deserializer.md
RX_WORD_DESERIALIZER -- requirements
Module: rx_word_deserializer

Interface
REQ-001 The block SHALL use one clock; reset is synchronous and active-high (ports CLK and RST).
REQ-002 Parameter DATA_WIDTH, default 8, SHALL set data bits per word (legal 5..9).
REQ-003 Parameter PRESC_WIDTH, default 6, SHALL set the width of edge_count and Prescale.
REQ-004 Parameter MSB_FIRST, default 0, SHALL select bit order (0 = LSB received first, 1 = MSB received first).
REQ-005 CLK  in  1  rising-edge clock for all state.
REQ-006 RST  in  1  synchronous active-high reset.
REQ-007 sampled_bit  in  1  majority-voted RX bit value.
REQ-008 Enable  in  1  data-phase enable from the RX FSM.
REQ-009 clear  in  1  start-of-frame pulse; discards any partial word.
REQ-010 edge_count  in  PRESC_WIDTH  oversampling edge counter.
REQ-011 Prescale  in  PRESC_WIDTH  oversampling ratio.
REQ-012 P_DATA  out  DATA_WIDTH  last completed word.
REQ-013 data_valid  out  1  one-cycle pulse when P_DATA is updated.
REQ-014 data_parity  out  1  XOR of all bits in P_DATA.
REQ-015 bit_cnt  out  $clog2(DATA_WIDTH+1)  bits captured in current word.

Function
REQ-016 The sample strobe SHALL be Enable AND (edge_count == Prescale - 1), with subtraction modulo 2^PRESC_WIDTH (Prescale = 0 compares against all-ones).
REQ-017 On a strobe, an internal shift register SHALL take sampled_bit: MSB_FIRST=0 -> {sampled_bit, sh[W-1:1]}; MSB_FIRST=1 -> {sh[W-2:0], sampled_bit}.
REQ-018 On a strobe, bit_cnt SHALL increment by 1.
REQ-019 When a strobe occurs with bit_cnt == DATA_WIDTH-1, the same edge SHALL load P_DATA with the completed word (including the current bit), load data_parity with its XOR, assert data_valid, and reset bit_cnt to 0.
REQ-020 data_valid SHALL be high for exactly one cycle per completed word; at all other times it SHALL be low.
REQ-021 P_DATA and data_parity SHALL hold their values between completions; partial words SHALL never be visible on P_DATA.
REQ-022 clear SHALL zero bit_cnt and the shift register on the next edge; clear SHALL take priority over a simultaneous strobe (that bit is dropped, no data_valid).
REQ-023 clear SHALL NOT alter P_DATA or data_parity.
REQ-024 With Enable low, edge_count/Prescale/sampled_bit SHALL have no effect on any state.
REQ-025 Back-to-back words SHALL need no idle cycle: the strobe after a completion starts the next word at bit 0.
REQ-026 Latency: data_valid and the new P_DATA SHALL appear on the clock edge that samples the last bit (registered, zero extra cycles).

Reset
REQ-027 RST high at a rising edge SHALL set P_DATA = 0, data_parity = 0, data_valid = 0, bit_cnt = 0, shift register = 0.
REQ-028 RST SHALL take priority over clear and strobe; a reset mid-word SHALL discard the partial word with no data_valid.

Structure
REQ-029 Default DATA_WIDTH, PRESC_WIDTH and the bit-order encoding SHALL be constants in the shared package uart_rx_pkg, reused by the RX FSM and sampler.
REQ-030 The block SHALL be a single module with no sub-module; strobe compare, counter, shift register and output register are all local.

Verification
REQ-031 DATA_WIDTH=8, MSB_FIRST=0, Prescale=8, bits 1,0,1,0,0,1,0,1 strobed at edge_count=7 -> P_DATA=0xA5, data_parity=0, data_valid high one cycle.
REQ-032 MSB_FIRST=1, same bit sequence -> P_DATA=0xA5 read MSB-first, i.e. 0xA5 for sequence 1,0,1,0,0,1,0,1, and LSB-first reverse sequence also yields 0xA5 in LSB mode.
REQ-033 Enable low or edge_count != Prescale-1 for 100 cycles with toggling sampled_bit -> bit_cnt stays 0, no data_valid.
REQ-034 After 4 bits, clear coinciding with a strobe -> bit_cnt=0, P_DATA unchanged; next 8 bits 0xFF -> P_DATA=0xFF, data_parity=0.
REQ-035 RST after 5 bits of word 2 (word 1 = 0x3C) -> all outputs 0; then word 0x81 -> P_DATA=0x81, data_parity=0.
REQ-036 DATA_WIDTH=7, two back-to-back words 0x55 then 0x2A with no gap -> two data_valid pulses, P_DATA=0x55 held until 7th bit of second word, then 0x2A.
